mpei_gpio_in_cond: RTL and testbench

MPEI_GPIO_IN_COND -- requirements
Module: mpei_gpio_in_cond

---
 rtl/mpei_gpio_pkg.sv | 23 ++
 rtl/mpei_gpio_deb_cell.sv | 73 +++++++
 rtl/mpei_gpio_in_cond.sv | 86 ++++++++
 tb/tb_mpei_gpio_in_cond.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpei_gpio_pkg.sv
// Shared constants and per-bit filter state for the GPIO input conditioner.
package mpei_gpio_pkg;

  localparam int NGPIO_DEF   = 32;
  localparam int PRESC_W_DEF = 16;
  localparam int DEB_W_DEF   = 4;

  // Counter storage width; DEB_W of an instance must not exceed it.
  localparam int DEB_CNT_W = 8;

  typedef logic [DEB_CNT_W-1:0] deb_cnt_t;

  typedef struct packed {
    logic     din;
    deb_cnt_t cnt;
  } deb_cell_t;

  // ">=" rather than "==" so a length lowered mid-count expires at once.
  function automatic logic deb_expired(input deb_cnt_t cnt, input deb_cnt_t len);
    return cnt >= len;
  endfunction

endpackage

// File: rtl/mpei_gpio_deb_cell.sv
// One GPIO bit: debounce filter on the synchronized level, edge pulses and
// sticky interrupt pending flag.
module mpei_gpio_deb_cell
  import mpei_gpio_pkg::*;
#(
  parameter int DEB_W = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s,
  input  logic             tick,
  input  logic             deb_en,
  input  logic [DEB_W-1:0] deb_len,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             irq_clr,
  output logic             din,
  output logic             rise,
  output logic             fall,
  output logic             pend
);

  deb_cell_t st_reg;
  deb_cell_t st_next;
  logic      rise_reg;
  logic      fall_reg;
  logic      pend_reg;
  logic      pend_next;
  deb_cnt_t  len_ext;

  assign len_ext = deb_cnt_t'(deb_len);

  // Bypass keeps the counter cleared so enabling the filter starts from zero.
  always_comb begin
    st_next = st_reg;
    if (!deb_en) begin
      st_next.din = s;
      st_next.cnt = '0;
    end else if (s == st_reg.din) begin
      st_next.cnt = '0;
    end else if (tick) begin
      if (deb_expired(st_reg.cnt, len_ext)) begin
        st_next.din = s;
        st_next.cnt = '0;
      end else begin
        st_next.cnt = st_reg.cnt + deb_cnt_t'(1);
      end
    end
  end

  // A set in the same cycle as a clear wins.
  assign pend_next = (rise_reg & rise_en) | (fall_reg & fall_en) | (pend_reg & ~irq_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_reg   <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      pend_reg <= 1'b0;
    end else begin
      st_reg   <= st_next;
      rise_reg <= st_next.din & ~st_reg.din;
      fall_reg <= ~st_next.din & st_reg.din;
      pend_reg <= pend_next;
    end
  end

  assign din  = st_reg.din;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign pend = pend_reg;

endmodule

// File: rtl/mpei_gpio_in_cond.sv
// GPIO input conditioner: pad synchronizer, shared sample prescaler and one
// debounce/edge/interrupt cell per pin.
module mpei_gpio_in_cond
  import mpei_gpio_pkg::*;
#(
  parameter int NGPIO   = NGPIO_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int DEB_W   = DEB_W_DEF
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NGPIO-1:0]   gpio_pad_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [DEB_W-1:0]   deb_len_i,
  input  logic [NGPIO-1:0]   deb_en_i,
  input  logic [NGPIO-1:0]   irq_rise_en_i,
  input  logic [NGPIO-1:0]   irq_fall_en_i,
  input  logic [NGPIO-1:0]   irq_clr_i,
  output logic [NGPIO-1:0]   gpio_din_o,
  output logic [NGPIO-1:0]   gpio_rise_o,
  output logic [NGPIO-1:0]   gpio_fall_o,
  output logic [NGPIO-1:0]   irq_pend_o,
  output logic               irq_o
);

  logic [NGPIO-1:0]   sync1_reg;
  logic [NGPIO-1:0]   sync2_reg;
  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [PRESC_W-1:0] presc_cnt_next;
  logic               tick;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= gpio_pad_i;
      sync2_reg <= sync1_reg;
    end
  end

  // A count stranded above a freshly lowered presc_i restarts without a tick.
  always_comb begin
    tick           = 1'b0;
    presc_cnt_next = presc_cnt_reg + PRESC_W'(1);
    if (presc_cnt_reg > presc_i) begin
      presc_cnt_next = '0;
    end else if (presc_cnt_reg == presc_i) begin
      tick           = 1'b1;
      presc_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NGPIO; gi++) begin : g_cell
      mpei_gpio_deb_cell #(
        .DEB_W (DEB_W)
      ) u_cell (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .s       (sync2_reg[gi]),
        .tick    (tick),
        .deb_en  (deb_en_i[gi]),
        .deb_len (deb_len_i),
        .rise_en (irq_rise_en_i[gi]),
        .fall_en (irq_fall_en_i[gi]),
        .irq_clr (irq_clr_i[gi]),
        .din     (gpio_din_o[gi]),
        .rise    (gpio_rise_o[gi]),
        .fall    (gpio_fall_o[gi]),
        .pend    (irq_pend_o[gi])
      );
    end
  endgenerate

  assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_mpei_gpio_in_cond.sv
// Scoreboarded bench: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares; directed scenarios plus random traffic.
module tb_mpei_gpio_in_cond;

  localparam int N  = 8;
  localparam int PW = 8;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn_i;
  logic [N-1:0]  pad, deb_en, rise_en, fall_en, clr;
  logic [PW-1:0] presc;
  logic [DW-1:0] deb_len;
  logic [N-1:0]  din, rise, fall, pend;
  logic          irq;

  mpei_gpio_in_cond #(.NGPIO(N), .PRESC_W(PW), .DEB_W(DW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .gpio_pad_i    (pad),
    .presc_i       (presc),
    .deb_len_i     (deb_len),
    .deb_en_i      (deb_en),
    .irq_rise_en_i (rise_en),
    .irq_fall_en_i (fall_en),
    .irq_clr_i     (clr),
    .gpio_din_o    (din),
    .gpio_rise_o   (rise),
    .gpio_fall_o   (fall),
    .irq_pend_o    (pend),
    .irq_o         (irq)
  );

  typedef struct packed {
    logic [N-1:0] din;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] pend;
    logic         irq;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model state: pad delay line, sample phase, per-pin level/count.
  logic [N-1:0] m_s1, m_s2, m_din, m_rise, m_fall, m_pend;
  int           m_cnt[N];
  int           m_pc;

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_din = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    m_pc = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at the edge.
  task automatic model_step();
    logic         tick;
    logic [N-1:0] din_new, pend_new;
    tick = (m_pc == int'(presc));
    if (m_pc >= int'(presc)) m_pc = 0;
    else                     m_pc = m_pc + 1;
    din_new = m_din;
    for (int i = 0; i < N; i++) begin
      if (!deb_en[i]) begin
        din_new[i] = m_s2[i];
        m_cnt[i]   = 0;
      end else if (m_s2[i] == m_din[i]) begin
        m_cnt[i] = 0;
      end else if (tick) begin
        if (m_cnt[i] >= int'(deb_len)) begin
          din_new[i] = m_s2[i];
          m_cnt[i]   = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    pend_new = (m_rise & rise_en) | (m_fall & fall_en) | (m_pend & ~clr);
    m_rise   = din_new & ~m_din;
    m_fall   = ~din_new & m_din;
    m_din    = din_new;
    m_pend   = pend_new;
    m_s2     = m_s1;
    m_s1     = pad;
  endtask

  // Advance one cycle; next_rstn is applied 1 ns after the edge (asynchronously).
  task automatic step(input logic next_rstn);
    exp_t e;
    @(posedge clk);
    if (!rstn_i || !next_rstn) model_reset();
    else                       model_step();
    e.din  = m_din;
    e.rise = m_rise;
    e.fall = m_fall;
    e.pend = m_pend;
    e.irq  = |m_pend;
    sb_q.push_back(e);
    #1 rstn_i = next_rstn;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      txn++;
      check_vec("sb_din", din, e.din);
      check_vec("sb_rise", rise, e.rise);
      check_vec("sb_fall", fall, e.fall);
      check_vec("sb_pend", pend, e.pend);
      check_bit("sb_irq", irq, e.irq);
      $display("txn %0d din=%h rise=%h fall=%h pend=%h irq=%b", txn, din, rise, fall, pend, irq);
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    logic found, seen;

    rstn_i = 1'b0; pad = '0; deb_en = '0; rise_en = '0; fall_en = '0; clr = '0;
    presc = '0; deb_len = '0;
    model_reset();

    step(0); step(0);
    check_vec("reset_din", din, '0);
    check_bit("reset_irq", irq, 1'b0);
    step(1);

    // Bypass latency on pin 0.
    repeat (6) step(1);
    pad[0] = 1'b1;
    step(1); step(1);
    check_bit("byp_din_c2", din[0], 1'b0);
    step(1);
    check_bit("byp_din_c3", din[0], 1'b1);
    check_bit("byp_rise_c3", rise[0], 1'b1);
    step(1);
    check_bit("byp_rise_c4", rise[0], 1'b0);

    // Filtered rise on pin 1: presc=3, deb_len=2.
    deb_en = 8'h02; presc = 8'd3; deb_len = 4'd2;
    repeat (4) step(1);
    pad[1] = 1'b1;
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      step(1);
      n++;
      if (din[1]) found = 1'b1;
    end
    check_int("filt_latency", found ? n : -1, 11, 14);
    check_bit("filt_rise", rise[1], 1'b1);

    // Glitch of 6 cycles must be rejected.
    pad[1] = 1'b0;
    repeat (20) step(1);
    check_bit("glitch_pre_din", din[1], 1'b0);
    seen = 1'b0;
    pad[1] = 1'b1;
    repeat (6) begin step(1); if (din[1] | rise[1]) seen = 1'b1; end
    pad[1] = 1'b0;
    repeat (25) begin step(1); if (din[1] | rise[1]) seen = 1'b1; end
    check_bit("glitch_seen", seen, 1'b0);

    // Rising-edge interrupt on pin 2, clear, then clear colliding with a set.
    rise_en = 8'h04;
    pad[2] = 1'b1;
    repeat (5) step(1);
    check_bit("irq_pend_set", pend[2], 1'b1);
    check_bit("irq_out_set", irq, 1'b1);
    clr = 8'h04;
    step(1);
    clr = '0;
    check_bit("irq_pend_clr", pend[2], 1'b0);
    pad[2] = 1'b0;
    repeat (6) step(1);
    pad[2] = 1'b1;
    step(1); step(1); step(1);
    check_bit("irq_rise_now", rise[2], 1'b1);
    clr = 8'h04;
    step(1);
    clr = '0;
    check_bit("irq_set_wins", pend[2], 1'b1);

    // Falling edge with fall_en=0: pulse but no pending.
    clr = 8'h04;
    step(1);
    clr = '0;
    pad[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(1); if (fall[2]) seen = 1'b1; end
    check_bit("fall_pulse_seen", seen, 1'b1);
    check_bit("fall_no_pend", pend[2], 1'b0);

    // Reset in the middle of a debounce on pin 1.
    pad[1] = 1'b1;
    repeat (6) step(1);
    step(0);
    #1;
    check_vec("rst_din_now", din, '0);
    check_vec("rst_pend_now", pend, '0);
    check_bit("rst_irq_now", irq, 1'b0);
    step(0);
    step(1);
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      step(1);
      n++;
      if (din[1]) found = 1'b1;
    end
    check_int("rst_restart_latency", found ? n : -1, 12, 12);

    // Random traffic, settings reshuffled periodically (incl. mid-count changes).
    for (int c = 0; c < 500; c++) begin
      if (c % 40 == 0) begin
        presc   = PW'($urandom_range(0, 4));
        deb_len = DW'($urandom_range(0, 3));
        deb_en  = N'($urandom);
        rise_en = N'($urandom);
        fall_en = N'($urandom);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pad[i] = ~pad[i];
      clr = N'($urandom & $urandom & $urandom);
      step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end
    clr = '0;
    repeat (3) step(1);
    @(negedge clk);
    #1;
    check_int("sb_drained", sb_q.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
